quadrature_encoder_emulator: RTL and testbench

Generates quadrature encoder signals (A, B, index) from a commanded edge rate and direction. It is the transmit-side counterpart of the quadrature decoder in the BLDC velocity loop. Used for hardware-in-the-loop and bench testing of the velocity controller without a physical motor. It also exposes the emulated position so checkers can compare it against the decoder's encoder_count.

---
 rtl/quadrature_pkg.sv | 41 ++++
 rtl/quadrature_step_timer.sv | 48 ++++
 rtl/quadrature_encoder_emulator.sv | 81 ++++++++
 tb/tb_quadrature_encoder_emulator.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/quadrature_pkg.sv
// Shared quadrature definitions used by the encoder emulator and the decoder.
// State encodings equal the {A,B} pattern of each state.
package quadrature_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b10,
    S2 = 2'b11,
    S3 = 2'b01
  } quad_state_t;

  // Forward walks S0->S1->S2->S3->S0; reverse walks the exact inverse.
  function automatic quad_state_t next_quad_state(input quad_state_t state,
                                                  input logic        direction);
    quad_state_t nxt;
    nxt = S0;
    unique case (state)
      S0:      nxt = direction ? S1 : S3;
      S1:      nxt = direction ? S2 : S0;
      S2:      nxt = direction ? S3 : S1;
      S3:      nxt = direction ? S0 : S2;
      default: nxt = S0;
    endcase
    return nxt;
  endfunction

  // Returns {A, B}.
  function automatic logic [1:0] quad_to_ab(input quad_state_t state);
    logic [1:0] ab;
    ab = 2'b00;
    unique case (state)
      S0:      ab = 2'b00;
      S1:      ab = 2'b10;
      S2:      ab = 2'b11;
      S3:      ab = 2'b01;
      default: ab = 2'b00;
    endcase
    return ab;
  endfunction

endpackage

// File: rtl/quadrature_step_timer.sv
// Period counter with minimum-period clamping and step/enable arbitration.
// Emits a one-cycle advance pulse that the top level registers as an edge.
module quadrature_step_timer
  import quadrature_pkg::*;
#(
  parameter int PERIOD_WIDTH = 32,
  parameter int MIN_PERIOD   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    step,
  input  logic [PERIOD_WIDTH-1:0] tick_period,
  output logic                    advance
);

  logic [PERIOD_WIDTH-1:0] count;
  logic [PERIOD_WIDTH-1:0] count_nxt;
  logic [PERIOD_WIDTH-1:0] eff_period;
  logic                    terminal;

  always_comb begin
    eff_period = (tick_period < PERIOD_WIDTH'(MIN_PERIOD)) ? PERIOD_WIDTH'(MIN_PERIOD)
                                                           : tick_period;
    // ">=" rather than "==" so a period lowered below the running count fires at once
    terminal   = (count >= (eff_period - PERIOD_WIDTH'(1)));
    advance    = 1'b0;
    count_nxt  = '0;
    if (!enable) begin
      advance = step;
    end else if (tick_period != '0) begin
      if (terminal) begin
        advance = 1'b1;
      end else begin
        count_nxt = count + PERIOD_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/quadrature_encoder_emulator.sv
// Quadrature encoder emulator: A/B/index generation from a commanded edge
// rate and direction, with a signed position count for cross-checking.
module quadrature_encoder_emulator
  import quadrature_pkg::*;
#(
  parameter int PERIOD_WIDTH   = 32,
  parameter int COUNT_WIDTH    = 32,
  parameter int COUNTS_PER_REV = 4096,
  parameter int MIN_PERIOD     = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          direction,
  input  logic [PERIOD_WIDTH-1:0]       tick_period,
  input  logic                          step,
  output logic                          encoder_a,
  output logic                          encoder_b,
  output logic                          encoder_index,
  output logic signed [COUNT_WIDTH-1:0] position,
  output logic                          tick
);

  localparam int REV_W = (COUNTS_PER_REV > 1) ? $clog2(COUNTS_PER_REV) : 1;
  localparam logic [REV_W-1:0] REV_LAST = REV_W'(COUNTS_PER_REV - 1);

  logic                          advance;
  quad_state_t                   state_q, state_d;
  logic signed [COUNT_WIDTH-1:0] position_d;
  logic [REV_W-1:0]              rev_q, rev_d;
  logic                          index_d;

  quadrature_step_timer #(
    .PERIOD_WIDTH (PERIOD_WIDTH),
    .MIN_PERIOD   (MIN_PERIOD)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .step        (step),
    .tick_period (tick_period),
    .advance     (advance)
  );

  always_comb begin
    state_d    = state_q;
    position_d = position;
    rev_d      = rev_q;
    if (advance) begin
      state_d = next_quad_state(state_q, direction);
      if (direction) begin
        position_d = position + COUNT_WIDTH'(1);
        rev_d      = (rev_q == REV_LAST) ? '0 : rev_q + REV_W'(1);
      end else begin
        position_d = position - COUNT_WIDTH'(1);
        rev_d      = (rev_q == '0) ? REV_LAST : rev_q - REV_W'(1);
      end
    end
    index_d = (rev_d == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S0;
      position      <= '0;
      rev_q         <= '0;
      encoder_index <= 1'b1;
      tick          <= 1'b0;
    end else begin
      state_q       <= state_d;
      position      <= position_d;
      rev_q         <= rev_d;
      encoder_index <= index_d;
      tick          <= advance;
    end
  end

  // A/B come straight from the Gray-coded state flops, so they cannot glitch.
  assign {encoder_a, encoder_b} = quad_to_ab(state_q);

endmodule

// File: tb/tb_quadrature_encoder_emulator.sv
// Self-checking bench for quadrature_encoder_emulator: directed scenarios plus
// randomized traffic, compared each cycle against a position-based model.
module tb_quadrature_encoder_emulator;

  localparam int CPR = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        direction = 1'b1;
  logic [31:0] tick_period = '0;
  logic        step = 1'b0;
  logic        encoder_a, encoder_b, encoder_index, tick;
  logic [31:0] position;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_fail   = 0;

  // Model: everything derives from the signed edge count plus elapsed cycles.
  int m_pos     = 0;
  int m_elapsed = 0;
  bit m_tick    = 1'b0;

  always #5 clk = ~clk;

  quadrature_encoder_emulator #(
    .PERIOD_WIDTH   (32),
    .COUNT_WIDTH    (32),
    .COUNTS_PER_REV (CPR),
    .MIN_PERIOD     (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .direction     (direction),
    .tick_period   (tick_period),
    .step          (step),
    .encoder_a     (encoder_a),
    .encoder_b     (encoder_b),
    .encoder_index (encoder_index),
    .position      (position),
    .tick          (tick)
  );

  function automatic logic [1:0] exp_ab(input int pos);
    int ph;
    ph = ((pos % 4) + 4) % 4;
    case (ph)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  function automatic logic exp_index(input int pos);
    return (((pos % CPR) + CPR) % CPR) == 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs();
    chk("tick", 32'(tick), 32'(m_tick));
    chk("ab", 32'({encoder_a, encoder_b}), 32'(exp_ab(m_pos)));
    chk("position", position, 32'(m_pos));
    chk("index", 32'(encoder_index), 32'(exp_index(m_pos)));
  endtask

  task automatic model_step();
    int p;
    m_tick = 1'b0;
    if (!enable) begin
      m_elapsed = 0;
      m_tick    = step;
    end else if (tick_period == 0) begin
      m_elapsed = 0;
    end else begin
      p = (tick_period < 2) ? 2 : int'(tick_period);
      m_elapsed++;
      if (m_elapsed >= p) begin
        m_tick    = 1'b1;
        m_elapsed = 0;
      end
    end
    if (m_tick) m_pos += direction ? 1 : -1;
  endtask

  task automatic model_reset();
    m_pos     = 0;
    m_elapsed = 0;
    m_tick    = 1'b0;
  endtask

  task automatic clk_cycle();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic run(input int n, output int ticks);
    ticks = 0;
    for (int i = 0; i < n; i++) begin
      clk_cycle();
      if (tick) ticks++;
    end
  endtask

  // Bounded wait for the next tick; returns limit+1 if none appears.
  task automatic wait_tick(input int limit, output int cycles);
    cycles = limit + 1;
    for (int i = 1; i <= limit; i++) begin
      clk_cycle();
      if (tick) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic check_reset_values();
    chk("rst_ab", 32'({encoder_a, encoder_b}), 32'(2'b00));
    chk("rst_position", position, 32'd0);
    chk("rst_index", 32'(encoder_index), 32'd1);
    chk("rst_tick", 32'(tick), 32'd0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    model_reset();
    check_reset_values();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic do_step();
    step = 1'b1;
    clk_cycle();
    chk("step_tick_next_cycle", 32'(tick), 32'd1);
    step = 1'b0;
  endtask

  initial begin
    int c;
    int t;
    int pos_before;

    // Free run, forward, period 10
    enable = 1'b0; direction = 1'b1; tick_period = '0; step = 1'b0;
    apply_reset();
    enable = 1'b1; tick_period = 32'd10;
    wait_tick(30, c);
    chk("first_tick_cycle", 32'(c), 32'd10);
    run(30, t);
    chk("fwd_ticks", 32'(t), 32'd3);
    chk("fwd_pos4", position, 32'd4);
    chk("fwd_ab_wrap", 32'({encoder_a, encoder_b}), 32'(2'b00));

    // Mid-interval reversal
    enable = 1'b0;
    apply_reset();
    enable = 1'b1; tick_period = 32'd10; direction = 1'b1;
    run(25, t);
    chk("rev_pre_pos", position, 32'd2);
    direction = 1'b0;
    run(5, t);
    chk("rev_single_tick", 32'(t), 32'd1);
    chk("rev_pos", position, 32'd1);
    chk("rev_ab_s1", 32'({encoder_a, encoder_b}), 32'(2'b10));

    // Single steps with enable low
    enable = 1'b0; direction = 1'b1;
    pos_before = int'(position);
    t = 0;
    for (int k = 0; k < 3; k++) begin
      do_step();
      t++;
      run(4, c);
      t += c;
    end
    chk("step_ticks", 32'(t), 32'd3);
    chk("step_pos", position, 32'(pos_before + 3));

    // step ignored while enabled; period 0 means stopped
    enable = 1'b1; tick_period = '0; step = 1'b1;
    run(10, t);
    step = 1'b0;
    run(90, c);
    chk("stopped_ticks", 32'(t + c), 32'd0);

    // Period 1 clamps to 2
    tick_period = 32'd1;
    run(20, t);
    chk("clamp_ticks", 32'(t), 32'd10);

    // Index across a full revolution
    enable = 1'b0; tick_period = '0;
    apply_reset();
    direction = 1'b1;
    for (int k = 0; k < CPR; k++) begin
      do_step();
      clk_cycle();
    end
    chk("rev_pos8", position, 32'd8);
    chk("rev_index8", 32'(encoder_index), 32'd1);

    // Reverse through zero
    apply_reset();
    direction = 1'b0;
    do_step();
    chk("neg_pos", position, 32'hFFFF_FFFF);
    chk("neg_index", 32'(encoder_index), 32'd0);
    direction = 1'b1;
    do_step();
    chk("zero_index", 32'(encoder_index), 32'd1);

    // Reset mid-interval
    enable = 1'b1; tick_period = 32'd10; direction = 1'b1;
    run(15, t);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_reset_values();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    wait_tick(30, c);
    chk("post_reset_first_tick", 32'(c), 32'd10);

    // Randomized traffic
    for (int blk = 0; blk < 20; blk++) begin
      enable      = ($urandom_range(0, 3) != 0);
      direction   = $urandom_range(0, 1);
      tick_period = 32'($urandom_range(0, 6));
      for (int i = 0; i < 20; i++) begin
        step = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 7) == 0) direction = ~direction;
        if ($urandom_range(0, 15) == 0) tick_period = 32'($urandom_range(0, 6));
        clk_cycle();
      end
    end
    step = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
